// File: rtl/biu_pkg.sv
// Shared encodings for the bus interface unit arbiter: transfer sizes,
// ack codes, arbiter state and transfer owner.
package biu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_BURST = 2'b11;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_DATA = 2'b01;
  localparam logic [1:0] ACK_ERR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_XFER
  } state_e;

  typedef enum logic {
    OWN_ICU,
    OWN_DCU
  } owner_e;

endpackage

// File: rtl/biu_beat_cnt.sv
// Beats-remaining counter: loaded at the start of the data phase and
// decremented on each data ack. Flags the last beat and an empty count.
module biu_beat_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; decrement never wraps below zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/biu_arb.sv
// Arbiter and transfer sequencer for the shared external memory port.
// Grants ICU or DCU, issues one address phase, counts data beats and routes
// acks and read data back to the owner until the final (or error) ack.
module biu_arb
  import biu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_BEATS  = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_req,
  input  logic [31:0] icu_biu_addr,
  input  logic [3:0]  icu_type,
  input  logic [1:0]  icu_size,
  output logic [1:0]  biu_icu_ack,
  input  logic        dcu_req,
  input  logic [31:0] dcu_addr,
  input  logic [3:0]  dcu_type,
  input  logic [1:0]  dcu_size,
  input  logic [31:0] dcu_wdata,
  output logic [1:0]  biu_dcu_ack,
  output logic [31:0] biu_data,
  output logic        pj_tv,
  output logic [31:0] pj_addr,
  output logic [3:0]  pj_type,
  output logic [1:0]  pj_size,
  output logic [31:0] pj_data_out,
  input  logic [31:0] pj_data_in,
  input  logic [1:0]  pj_ack,
  output logic        arb_busy
);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_BEATS);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [31:0]      addr_q;
  logic [3:0]       type_q;
  logic [1:0]       size_q;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             grant;
  logic             beat_load, beat_dec, beat_zero, beat_last;
  logic [1:0]       ack_fwd;

  // Next-state, arbitration and starvation bookkeeping.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    grant     = 1'b0;
    beat_load = 1'b0;
    beat_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (icu_req || dcu_req) begin
          grant   = 1'b1;
          state_d = ST_ADDR;
          // DCU wins ties unless the ICU has been passed over STARVE_LIMIT times.
          if (dcu_req && !(icu_req && (starve_q == STARVE_MAX))) begin
            owner_d  = OWN_DCU;
            starve_d = !icu_req ? '0 :
                       (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
          end else begin
            owner_d  = OWN_ICU;
            starve_d = '0;
          end
        end
      end
      ST_ADDR: begin
        state_d   = ST_XFER;
        beat_load = 1'b1;
      end
      ST_XFER: begin
        if (pj_ack == ACK_ERR) begin
          state_d = ST_IDLE;
        end else if (pj_ack == ACK_DATA) begin
          beat_dec = 1'b1;
          if (beat_last) state_d = ST_IDLE;
        end else if (beat_zero) begin
          // Defensive: an empty count in XFER can only mean a lost load.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner and starvation registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_ICU;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Winner's request bundle, captured only at grant and held for the transfer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these are ordinary control registers, so they get an async reset; reset must zero the pin outputs.
    if (reset) begin
      addr_q <= '0;
      type_q <= '0;
      size_q <= '0;
    end else if (grant) begin
      addr_q <= (owner_d == OWN_DCU) ? dcu_addr : icu_biu_addr;
      type_q <= (owner_d == OWN_DCU) ? dcu_type : icu_type;
      size_q <= (owner_d == OWN_DCU) ? dcu_size : icu_size;
    end
  end

  biu_beat_cnt #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (beat_load),
    .load_val_i ((size_q == SZ_BURST) ? BURST_LOAD : CNT_W'(1)),
    .dec_i      (beat_dec),
    .zero_o     (beat_zero),
    .last_o     (beat_last)
  );

  // Memory acks are only meaningful during the data phase.
  assign ack_fwd = ((state_q == ST_XFER) && ((pj_ack == ACK_DATA) || (pj_ack == ACK_ERR)))
                   ? pj_ack : ACK_NONE;

  assign biu_icu_ack = (owner_q == OWN_ICU) ? ack_fwd : ACK_NONE;
  assign biu_dcu_ack = (owner_q == OWN_DCU) ? ack_fwd : ACK_NONE;
  assign biu_data    = (ack_fwd == ACK_DATA) ? pj_data_in : '0;

  assign pj_tv    = (state_q == ST_ADDR);
  assign pj_addr  = addr_q;
  assign pj_type  = type_q;
  assign pj_size  = size_q;
  assign arb_busy = (state_q != ST_IDLE);

  assign pj_data_out = (arb_busy && (owner_q == OWN_DCU) && type_q[0]) ? dcu_wdata : '0;

endmodule

// File: tb/tb_biu_arb.sv
// Self-checking bench for biu_arb: directed scenarios plus randomized
// transaction traffic checked against a transaction-level arbitration model.
module tb_biu_arb;
  import biu_pkg::*;

  localparam int LIM = 4;
  localparam int BB  = 4;
  localparam logic [31:0] WBASE = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        icu_req, dcu_req;
  logic [31:0] icu_biu_addr, dcu_addr, dcu_wdata, pj_data_in;
  logic [3:0]  icu_type, dcu_type;
  logic [1:0]  icu_size, dcu_size, pj_ack;
  logic [1:0]  biu_icu_ack, biu_dcu_ack, pj_size;
  logic [31:0] biu_data, pj_addr, pj_data_out;
  logic [3:0]  pj_type;
  logic        pj_tv, arb_busy;

  int vectors     = 0;
  int miscompares = 0;
  int starve_m    = 0;   // model: consecutive DCU wins while ICU was waiting

  always #5 clk = ~clk;

  biu_arb #(.STARVE_LIMIT(LIM), .BURST_BEATS(BB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .icu_req(icu_req), .icu_biu_addr(icu_biu_addr), .icu_type(icu_type),
    .icu_size(icu_size), .biu_icu_ack(biu_icu_ack),
    .dcu_req(dcu_req), .dcu_addr(dcu_addr), .dcu_type(dcu_type),
    .dcu_size(dcu_size), .dcu_wdata(dcu_wdata), .biu_dcu_ack(biu_dcu_ack),
    .biu_data(biu_data), .pj_tv(pj_tv), .pj_addr(pj_addr), .pj_type(pj_type),
    .pj_size(pj_size), .pj_data_out(pj_data_out), .pj_data_in(pj_data_in),
    .pj_ack(pj_ack), .arb_busy(arb_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_icu(input logic [31:0] a, input logic [3:0] t, input logic [1:0] s);
    icu_req = 1'b1; icu_biu_addr = a; icu_type = t; icu_size = s;
  endtask

  task automatic start_dcu(input logic [31:0] a, input logic [3:0] t, input logic [1:0] s);
    dcu_req = 1'b1; dcu_addr = a; dcu_type = t; dcu_size = s;
  endtask

  // Wait (bounded) for the address phase, predict the winner from the
  // requests seen at the grant edge, and check the registered bundle.
  task automatic grant_check(output bit dcu_won);
    bit seen = 1'b0;
    bit icu_r = 1'b0, dcu_r = 1'b0;
    int lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      icu_r = icu_req; dcu_r = dcu_req; lat = i;
      tick();
      seen = pj_tv;
    end
    dcu_won = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL grant_timeout: pj_tv never rose (got 0, want 1)");
      return;
    end
    vectors++;
    if (lat !== 0) begin
      miscompares++;
      $display("FAIL grant_latency: got %0d extra cycles, want 0", lat);
    end
    dcu_won = dcu_r && !(icu_r && starve_m == LIM);
    if (dcu_won) starve_m = icu_r ? ((starve_m < LIM) ? starve_m + 1 : LIM) : 0;
    else         starve_m = 0;
    vectors++;
    if (pj_addr !== (dcu_won ? dcu_addr : icu_biu_addr)) begin
      miscompares++;
      $display("FAIL grant_addr: got %h want %h", pj_addr, dcu_won ? dcu_addr : icu_biu_addr);
    end
    vectors++;
    if ({pj_type, pj_size, arb_busy} !== (dcu_won ? {dcu_type, dcu_size, 1'b1} : {icu_type, icu_size, 1'b1})) begin
      miscompares++;
      $display("FAIL grant_type_size_busy: got %h/%h/%b want %h/%h/1", pj_type, pj_size, arb_busy,
               dcu_won ? dcu_type : icu_type, dcu_won ? dcu_size : icu_size);
    end
  endtask

  // Act as the memory for one granted transfer, starting on the pj_tv cycle.
  // gap < 0 selects a random 0..2 idle cycles before each beat.
  task automatic serve(input bit dcu_own, input int gap, input int err_beat, input bit keep);
    int nb = (((dcu_own ? dcu_size : icu_size) == SZ_BURST) ? BB : 1);
    bit wr = dcu_own && dcu_type[0];
    int pulses = 0;
    int want_pulses = (err_beat >= 1 && err_beat <= nb) ? err_beat - 1 : nb;
    logic [1:0] own_ack, oth_ack;
    pj_ack = ($urandom_range(0, 1) != 0) ? ACK_DATA : ACK_NONE;
    #1;
    vectors++;
    if ({biu_icu_ack, biu_dcu_ack} !== 4'b0000) begin
      miscompares++;
      $display("FAIL addr_phase_ack_ignored: got %b/%b want 00/00", biu_icu_ack, biu_dcu_ack);
    end
    for (int b = 1; b <= nb; b++) begin
      int g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int k = 0; k < g; k++) begin
        tick();
        pj_ack = ACK_NONE; dcu_wdata = WBASE + 32'(b);
        #1;
        vectors++;
        if ({biu_icu_ack, biu_dcu_ack, pj_tv, arb_busy} !== 6'b000001 ||
            pj_data_out !== (wr ? dcu_wdata : 32'h0)) begin
          miscompares++;
          $display("FAIL wait_cycle: got ack %b/%b tv %b busy %b wdo %h want 00/00 0 1 %h",
                   biu_icu_ack, biu_dcu_ack, pj_tv, arb_busy, pj_data_out, wr ? dcu_wdata : 32'h0);
        end
      end
      tick();
      pj_ack = (b == err_beat) ? ACK_ERR : ACK_DATA;
      pj_data_in = $urandom; dcu_wdata = WBASE + 32'(b);
      #1;
      own_ack = dcu_own ? biu_dcu_ack : biu_icu_ack;
      oth_ack = dcu_own ? biu_icu_ack : biu_dcu_ack;
      if (own_ack === ACK_DATA) pulses++;
      vectors++;
      if (own_ack !== pj_ack || oth_ack !== ACK_NONE || pj_tv !== 1'b0) begin
        miscompares++;
        $display("FAIL beat_ack: beat %0d got owner %b other %b tv %b want %b 00 0",
                 b, own_ack, oth_ack, pj_tv, pj_ack);
      end
      vectors++;
      if (pj_data_out !== (wr ? dcu_wdata : 32'h0)) begin
        miscompares++;
        $display("FAIL write_data: beat %0d got %h want %h", b, pj_data_out, wr ? dcu_wdata : 32'h0);
      end
      if (pj_ack == ACK_DATA) begin
        vectors++;
        if (biu_data !== pj_data_in) begin
          miscompares++;
          $display("FAIL read_data: beat %0d got %h want %h", b, biu_data, pj_data_in);
        end
      end
      if (b == err_beat) break;
    end
    tick();
    pj_ack = ACK_NONE;
    if (!keep) begin
      if (dcu_own) dcu_req = 1'b0; else icu_req = 1'b0;
    end
    #1;
    vectors++;
    if ({arb_busy, pj_tv, biu_icu_ack, biu_dcu_ack} !== 6'b0) begin
      miscompares++;
      $display("FAIL return_idle: got busy %b tv %b ack %b/%b want 0 0 00/00",
               arb_busy, pj_tv, biu_icu_ack, biu_dcu_ack);
    end
    vectors++;
    if (pulses !== want_pulses) begin
      miscompares++;
      $display("FAIL ack_pulses: got %0d want %0d", pulses, want_pulses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    icu_req = 0; dcu_req = 0; icu_biu_addr = 0; icu_type = 0; icu_size = 0;
    dcu_addr = 0; dcu_type = 0; dcu_size = 0; dcu_wdata = 0; pj_data_in = 0; pj_ack = 0;
    tick(); tick();
    vectors++;
    if ({biu_icu_ack, biu_dcu_ack, biu_data, pj_tv, pj_addr, pj_type, pj_size, arb_busy, pj_data_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr %h busy %b tv %b want all zero", pj_addr, arb_busy, pj_tv);
    end
    reset = 1'b0;
    starve_m = 0;
    tick();
  endtask

  task automatic test_icu_word();
    bit w;
    start_icu(32'h0000_1000, 4'h0, SZ_WORD);
    grant_check(w);
    serve(w, 2, 0, 1'b0);
  endtask

  task automatic test_icu_burst();
    bit w;
    start_icu($urandom & 32'hFFFF_FFF0, 4'($urandom), SZ_BURST);
    grant_check(w);
    serve(w, 1, 0, 1'b0);
  endtask

  task automatic test_starve();
    bit w;
    start_icu(32'h0000_2000, 4'h2, SZ_WORD);
    start_dcu(32'h0000_3000, 4'h0, SZ_WORD);
    for (int i = 0; i < 5; i++) begin
      grant_check(w);
      vectors++;
      if (w !== (i < 4)) begin
        miscompares++;
        $display("FAIL starve_order: grant %0d got dcu=%b want dcu=%b", i + 1, w, (i < 4));
      end
      serve(w, -1, 0, w);
    end
    // ICU asks again right away: the cleared counter means DCU wins first.
    start_icu(32'h0000_2040, 4'h2, SZ_WORD);
    grant_check(w);
    vectors++;
    if (w !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_cleared: got dcu=%b want dcu=1", w);
    end
    serve(w, 0, 0, 1'b0);
    grant_check(w);
    serve(w, 0, 0, 1'b0);
  endtask

  task automatic test_dcu_burst_err();
    bit w;
    start_dcu(32'h0000_4000, 4'h1, SZ_BURST);
    grant_check(w);
    serve(w, -1, 2, 1'b0);
  endtask

  task automatic test_reset_midburst();
    bit w;
    start_icu(32'h0000_5000, 4'h4, SZ_BURST);
    grant_check(w);
    tick(); pj_ack = ACK_DATA; pj_data_in = $urandom;
    start_dcu(32'h0000_6000, 4'h0, SZ_HALF);
    tick(); pj_ack = ACK_DATA; pj_data_in = $urandom; reset = 1'b1;
    #1;
    vectors++;
    if ({biu_icu_ack, biu_dcu_ack, biu_data, pj_tv, pj_addr, pj_type, pj_size, arb_busy, pj_data_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_midburst: got ack %b data %h addr %h busy %b want all zero",
               biu_icu_ack, biu_data, pj_addr, arb_busy);
    end
    tick();
    reset = 1'b0; icu_req = 1'b0; pj_ack = ACK_NONE; starve_m = 0;
    grant_check(w);
    vectors++;
    if (w !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_then_dcu: got dcu=%b want 1", w);
    end
    serve(w, -1, 0, 1'b0);
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 4; i++) begin
      tick(); pj_ack = ACK_DATA; pj_data_in = $urandom;
      #1;
      vectors++;
      if ({biu_icu_ack, biu_dcu_ack, arb_busy, pj_tv} !== 6'b0) begin
        miscompares++;
        $display("FAIL idle_ack_ignored: got %b/%b busy %b tv %b want 00/00 0 0",
                 biu_icu_ack, biu_dcu_ack, arb_busy, pj_tv);
      end
    end
    tick(); pj_ack = ACK_NONE;
  endtask

  task automatic test_random();
    bit w;
    int err;
    for (int n = 0; n < 40; n++) begin
      if (!icu_req && $urandom_range(0, 1) != 0) start_icu($urandom, 4'($urandom), 2'($urandom));
      if (!dcu_req && $urandom_range(0, 1) != 0) start_dcu($urandom, 4'($urandom), 2'($urandom));
      if (!icu_req && !dcu_req) start_dcu($urandom, 4'($urandom), 2'($urandom));
      grant_check(w);
      err = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      serve(w, -1, err, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_icu_word();
    test_icu_burst();
    test_starve();
    test_dcu_burst_err();
    test_idle_ack();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/biu_arb.md
Name: biu_arb

Overview:
Arbiter and transfer sequencer for the single external memory port shared by the instruction cache unit and the data cache unit. It accepts the ICU request bundle (icu_req, icu_biu_addr, icu_type, icu_size) and the DCU request bundle, and grants one requester at a time. It issues the address phase on the memory port, counts data beats and routes acks and read data back to the owner. It sits between icu/dcu and the pins and holds each grant until the final ack of a single or burst transfer.

Parameters:
STARVE_LIMIT, 4, consecutive DCU grants while ICU waits before ICU is forced to win
BURST_BEATS, 4, beats for size 2'b11 (line fill / writeback)
CNT_W, 3, width of beat and starvation counters (must hold BURST_BEATS and STARVE_LIMIT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
icu_req  in  1  ICU request, held until final ack
icu_biu_addr  in  32  ICU address
icu_type  in  4  ICU transaction type
icu_size  in  2  00 byte, 01 half, 10 word, 11 burst
biu_icu_ack  out  2  00 none, 01 data, 10 error
dcu_req  in  1  DCU request, held until final ack
dcu_addr  in  32  DCU address
dcu_type  in  4  DCU type; bit0=1 is a write
dcu_size  in  2  as icu_size
dcu_wdata  in  32  DCU write data for the current beat
biu_dcu_ack  out  2  as biu_icu_ack
biu_data  out  32  read data to both units, valid with an ack 01
pj_tv  out  1  address-phase strobe, one cycle per transfer
pj_addr  out  32  registered address
pj_type  out  4  registered type
pj_size  out  2  registered size
pj_data_out  out  32  write data, equals dcu_wdata while DCU owns a write
pj_data_in  in  32  read data from memory
pj_ack  in  2  memory ack, same encoding
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state including mid-burst):
  - State goes to IDLE; beat and starvation counters go to 0.
  - All outputs are 0: acks 00, pj_tv 0, pj_addr/type/size 0, biu_data 0, arb_busy 0.
  - An in-flight transfer is abandoned with no ack.
- States: IDLE, ADDR, XFER. The owner register (ICU/DCU) is loaded on leaving IDLE.
- IDLE, priority when both requests are seen in cycle N:
  - DCU wins by default.
  - ICU wins when starve_cnt == STARVE_LIMIT.
- IDLE, grant:
  - The winner's addr/type/size are registered.
  - The state moves to ADDR at cycle N+1, so pj_tv=1 at N+1 for exactly one cycle.
- ADDR to XFER next cycle. beats_left = BURST_BEATS if size==11, else 1.
- XFER:
  - pj_ack 01: forward to the owner's ack output and route pj_data_in to biu_data in the same cycle (combinational path), then decrement beats_left.
  - At 0, return to IDLE. No new address phase is issued earlier than 1 cycle after the final ack.
  - pj_ack 10: forward error to the owner and return to IDLE immediately. Remaining beats are cancelled.
  - The non-owner's ack is always 00.
- pj_ack is ignored in IDLE and ADDR.
- Starvation counter:
  - Incremented on each DCU grant while icu_req=1.
  - Cleared on an ICU grant or whenever icu_req=0 at grant time.
  - Saturates at STARVE_LIMIT.
- A request deasserted in IDLE before a grant is not serviced. Request bundles are otherwise sampled only at grant.
- pj_data_out is 0 unless owner=DCU and dcu_type[0]=1.

Decomposition:
- Package biu_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BURST
  - ack codes ACK_NONE/ACK_DATA/ACK_ERR
  - state enum and owner enum
- One sub-module: biu_beat_cnt (load/decrement/zero-flag counter), used for beats_left.
- The starvation counter is inline.

Test Plan:
- ICU-only word read at 0x0000_1000, pj_ack=01 three cycles after pj_tv -> one biu_icu_ack=01 with biu_data=pj_data_in, arb_busy low the following cycle.
- ICU burst (size 11) with acks on 4 non-consecutive cycles -> exactly 4 biu_icu_ack=01 pulses, then IDLE; pj_tv pulses once.
- Simultaneous icu_req and dcu_req held continuously, single-beat DCU transfers -> 4 DCU grants, then ICU granted on the 5th; starve_cnt cleared.
- DCU burst write of 0xA5A5_0001..4 -> pj_data_out tracks dcu_wdata each beat; error ack on beat 2 -> biu_dcu_ack=10 and return to IDLE, no further acks.
- reset asserted on beat 2 of an ICU burst -> all outputs 0 in the same cycle; after release, a pending dcu_req is granted with a fresh pj_tv.
- pj_ack=01 in IDLE with no request -> both ack outputs stay 00 and the state stays IDLE.
